// File: rtl/mcp4822_dual_channel_scheduler.sv
// mcp4822_dual_channel_scheduler
// Sequences DAC updates for both outputs of an MCP4822. Two producers (A, B)
// hand over 12-bit samples on valid/ready; each channel has a one-deep holding
// register. A round-robin arbiter grants one pending channel at a time. The
// Tx level of the granted serializer instance is then held high for one
// conversion frame, followed by an idle gap.
//
// Ports
//   clk, rst             : system clock, asynchronous active-high reset
//   i_a_valid/i_a_data   : channel A sample in;  o_a_ready = holding reg empty
//   i_b_valid/i_b_data   : channel B sample in;  o_b_ready = holding reg empty
//   o_tx_a, o_tx_b       : Tx levels to the A / B serializer (registered)
//   o_data               : sample presented to both serializers for the frame
//   o_sel                : pin mux select (0 = A instance, 1 = B instance)
//   i_cc                 : conversion-complete flag of the selected instance
//   o_done               : high on the last frame cycle
//   o_cc_err             : high with o_done if i_cc never rose during the frame
//   o_busy               : high in FRAME and GAP
module mcp4822_dual_channel_scheduler #(
   parameter int unsigned FRAME_CYCLES = 2500,
   parameter int unsigned GAP_CYCLES   = 4,
   parameter logic        FIRST_CH     = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_a_valid,
   input  logic [11:0] i_a_data,
   output logic        o_a_ready,
   input  logic        i_b_valid,
   input  logic [11:0] i_b_data,
   output logic        o_b_ready,
   output logic        o_tx_a,
   output logic        o_tx_b,
   output logic [11:0] o_data,
   output logic        o_sel,
   input  logic        i_cc,
   output logic        o_done,
   output logic        o_cc_err,
   output logic        o_busy
);

   localparam int unsigned DW = 12;
   localparam int unsigned CW = 12;
   localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FRAME = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t          state;
   logic            pend_a;
   logic            pend_b;
   logic [DW-1:0]   hold_a;
   logic [DW-1:0]   hold_b;
   logic [CW-1:0]   cnt;
   logic            last_ch;
   logic            cc_seen;

   logic            grant_en_c;
   logic            grant_ch_c;
   logic            frame_last_c;

   // Ready depends only on the holding register state, never on valid.
   assign o_a_ready = ~pend_a;
   assign o_b_ready = ~pend_b;

   // Round-robin pick: a lone pending channel wins; on a tie the channel not
   // served last wins.
   assign grant_en_c   = (state == ST_IDLE) && (pend_a || pend_b);
   assign grant_ch_c   = (pend_a && pend_b) ? ~last_ch : pend_b;
   assign frame_last_c = (state == ST_FRAME) && (cnt == FRAME_LAST);

   // Done/error must include i_cc of the last frame cycle itself, so they are
   // decoded from the current state rather than registered a cycle late.
   assign o_done   = frame_last_c;
   assign o_cc_err = frame_last_c && !(cc_seen || i_cc);
   assign o_busy   = (state != ST_IDLE);

   // Holding registers, arbitration and frame/gap sequencing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         pend_a  <= 1'b0;
         pend_b  <= 1'b0;
         hold_a  <= '0;
         hold_b  <= '0;
         cnt     <= '0;
         last_ch <= ~FIRST_CH;
         cc_seen <= 1'b0;
         o_tx_a  <= 1'b0;
         o_tx_b  <= 1'b0;
         o_data  <= '0;
         o_sel   <= FIRST_CH;
      end else begin
         // Accepts never collide with a grant of the same channel: a grant
         // needs pend=1, an accept needs pend=0.
         if (i_a_valid && !pend_a) begin
            pend_a <= 1'b1;
            hold_a <= i_a_data;
         end
         if (i_b_valid && !pend_b) begin
            pend_b <= 1'b1;
            hold_b <= i_b_data;
         end

         case (state)
            ST_IDLE: begin
               if (grant_en_c) begin
                  o_data  <= grant_ch_c ? hold_b : hold_a;
                  o_sel   <= grant_ch_c;
                  last_ch <= grant_ch_c;
                  o_tx_a  <= ~grant_ch_c;
                  o_tx_b  <= grant_ch_c;
                  cnt     <= '0;
                  cc_seen <= 1'b0;
                  state   <= ST_FRAME;
                  // Freeing the holding register here lets the producer
                  // refill it during its own frame.
                  if (grant_ch_c) begin
                     pend_b <= 1'b0;
                  end else begin
                     pend_a <= 1'b0;
                  end
               end
            end

            ST_FRAME: begin
               cc_seen <= cc_seen | i_cc;
               if (cnt == FRAME_LAST) begin
                  o_tx_a <= 1'b0;
                  o_tx_b <= 1'b0;
                  cnt    <= '0;
                  state  <= ST_GAP;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            ST_GAP: begin
               if (cnt == GAP_LAST) begin
                  cnt   <= '0;
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            default: begin
               o_tx_a <= 1'b0;
               o_tx_b <= 1'b0;
               cnt    <= '0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mcp4822_dual_channel_scheduler.sv
// Bench for mcp4822_dual_channel_scheduler: directed scenario table, hand
// sequences for back-to-back grants and mid-frame reset, then random traffic
// checked every cycle against a frame-timing reference model.
module tb_mcp4822_dual_channel_scheduler;

   localparam int FRAME   = 2500;
   localparam int GAP     = 4;
   localparam int SPACING = FRAME + GAP + 1;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        a_valid = 1'b0;
   logic [11:0] a_data = '0;
   logic        b_valid = 1'b0;
   logic [11:0] b_data = '0;
   logic        i_cc = 1'b0;
   logic        o_a_ready, o_b_ready, o_tx_a, o_tx_b, o_sel, o_done, o_cc_err, o_busy;
   logic [11:0] o_data;

   mcp4822_dual_channel_scheduler #(
      .FRAME_CYCLES(FRAME),
      .GAP_CYCLES  (GAP),
      .FIRST_CH    (1'b0)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .i_a_valid(a_valid),
      .i_a_data (a_data),
      .o_a_ready(o_a_ready),
      .i_b_valid(b_valid),
      .i_b_data (b_data),
      .o_b_ready(o_b_ready),
      .o_tx_a   (o_tx_a),
      .o_tx_b   (o_tx_b),
      .o_data   (o_data),
      .o_sel    (o_sel),
      .i_cc     (i_cc),
      .o_done   (o_done),
      .o_cc_err (o_cc_err),
      .o_busy   (o_busy)
   );

   always #4 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: pending flags, per-channel scoreboard queues and the
   // edge number of the latest grant; all outputs follow from arithmetic on
   // the distance to that grant.
   longint      edge_no;
   longint      m_grant_edge;
   longint      m_next_ok;
   longint      d;
   bit          m_pend_a, m_pend_b, m_last, m_g, m_sel, old_a, old_b, g;
   logic [11:0] m_data;
   logic [11:0] q_a[$];
   logic [11:0] q_b[$];
   bit          cc_any;

   // Observed frame log.
   bit          log_ch[$];
   logic [11:0] log_data[$];
   bit          log_err[$];
   longint      log_edge[$];
   int          done_cnt = 0;
   bit          prev_a, prev_b, prev_busy;
   logic [12:0] prev_sd;
   logic [19:0] exp_vec;
   bit          in_frame, e_done;

   typedef struct {
      bit          a_v;
      logic [11:0] a_d;
      bit          b_v;
      logic [11:0] b_d;
      int          cc_mode;   // 0 tie low, 1 tie high, 2 one pulse mid first frame
      int          n_frames;
      bit          e_ch0;
      logic [11:0] e_d0;
      bit          e_err0;
      bit          e_ch1;
      logic [11:0] e_d1;
      bit          e_err1;
   } vec_t;

   vec_t vecs[5];

   function automatic logic [19:0] outs();
      return {o_tx_a, o_tx_b, o_sel, o_data, o_done, o_cc_err, o_busy, o_a_ready, o_b_ready};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pend_a     = 1'b0;
      m_pend_b     = 1'b0;
      q_a.delete();
      q_b.delete();
      m_last       = 1'b1;
      m_sel        = 1'b0;
      m_g          = 1'b0;
      m_data       = '0;
      m_grant_edge = -64'sd1000000;
      m_next_ok    = 0;
   endtask

   task automatic model_step();
      edge_no++;
      old_a = m_pend_a;
      old_b = m_pend_b;
      if (edge_no >= m_next_ok && (old_a || old_b)) begin
         g            = (old_a && old_b) ? ~m_last : old_b;
         m_last       = g;
         m_sel        = g;
         m_g          = g;
         m_grant_edge = edge_no;
         m_next_ok    = edge_no + SPACING;
         if (g) begin
            m_data   = q_b.pop_front();
            m_pend_b = 1'b0;
         end else begin
            m_data   = q_a.pop_front();
            m_pend_a = 1'b0;
         end
      end
      if (a_valid && !old_a) begin
         q_a.push_back(a_data);
         m_pend_a = 1'b1;
      end
      if (b_valid && !old_b) begin
         q_b.push_back(b_data);
         m_pend_b = 1'b1;
      end
   endtask

   task automatic monitor_cycle();
      d        = edge_no - m_grant_edge;
      in_frame = (d >= 0) && (d < FRAME);
      if (d == 0) cc_any = 1'b0;
      if (in_frame && i_cc) cc_any = 1'b1;
      e_done   = (d == FRAME - 1);
      exp_vec  = {in_frame && !m_g, in_frame && m_g, m_sel, m_data, e_done,
                  e_done && !cc_any, (d >= 0) && (d < FRAME + GAP), !m_pend_a, !m_pend_b};
      check("cycle_outs", 32'(outs()), 32'(exp_vec));
      check("tx_exclusive", 32'(o_tx_a & o_tx_b), 32'd0);
      if (o_busy && prev_busy) check("hold_stable", 32'({o_sel, o_data}), 32'(prev_sd));
      if ((o_tx_a && !prev_a) || (o_tx_b && !prev_b)) begin
         log_ch.push_back(o_sel);
         log_data.push_back(o_data);
         log_edge.push_back(edge_no);
      end
      if (o_done) begin
         log_err.push_back(o_cc_err);
         done_cnt++;
      end
      prev_a    = o_tx_a;
      prev_b    = o_tx_b;
      prev_busy = o_busy;
      prev_sd   = {o_sel, o_data};
   endtask

   task automatic clear_logs();
      log_ch.delete();
      log_data.delete();
      log_err.delete();
      log_edge.delete();
   endtask

   task automatic reset_dut();
      @(posedge clk);
      #1;
      rst     = 1'b1;
      a_valid = 1'b0;
      b_valid = 1'b0;
      i_cc    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      clear_logs();
   endtask

   task automatic wait_dones(input int target, input int budget);
      int k = 0;
      while (done_cnt < target && k < budget) begin
         @(posedge clk);
         k++;
      end
      check("wait_done", 32'(done_cnt >= target), 32'd1);
   endtask

   int  base;
   bit  acc;
   int  k;

   initial begin
      vecs[0] = '{1'b1, 12'h123, 1'b0, 12'h000, 0, 1, 1'b0, 12'h123, 1'b1, 1'b0, 12'h000, 1'b0};
      vecs[1] = '{1'b0, 12'h000, 1'b1, 12'hABC, 1, 1, 1'b1, 12'hABC, 1'b0, 1'b0, 12'h000, 1'b0};
      vecs[2] = '{1'b1, 12'h111, 1'b1, 12'h222, 1, 2, 1'b0, 12'h111, 1'b0, 1'b1, 12'h222, 1'b0};
      vecs[3] = '{1'b1, 12'hFFF, 1'b1, 12'h000, 2, 2, 1'b0, 12'hFFF, 1'b0, 1'b1, 12'h000, 1'b1};
      vecs[4] = '{1'b1, 12'h000, 1'b0, 12'h000, 2, 1, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b0};

      edge_no   = 0;
      cc_any    = 1'b0;
      prev_a    = 1'b0;
      prev_b    = 1'b0;
      prev_busy = 1'b0;
      prev_sd   = '0;
      model_reset();

      fork
         forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
         end
         begin
            #2000000;
            $display("FAIL watchdog: simulation time limit reached");
            $fatal(1, "watchdog");
         end
      join_none

      reset_dut();
      check("reset_values", 32'(outs()), 32'({3'b000, 12'h000, 5'b00011}));

      fork
         forever begin
            @(negedge clk);
            monitor_cycle();
         end
      join_none

      // Directed scenario table.
      for (int i = 0; i < 5; i++) begin
         reset_dut();
         base    = done_cnt;
         i_cc    = (vecs[i].cc_mode == 1);
         a_valid = vecs[i].a_v;
         a_data  = vecs[i].a_d;
         b_valid = vecs[i].b_v;
         b_data  = vecs[i].b_d;
         @(posedge clk);
         #1;
         a_valid = 1'b0;
         b_valid = 1'b0;
         if (vecs[i].cc_mode == 2) begin
            repeat (1000) @(posedge clk);
            #1 i_cc = 1'b1;
            @(posedge clk);
            #1 i_cc = 1'b0;
         end
         wait_dones(base + vecs[i].n_frames, vecs[i].n_frames * SPACING + 50);
         @(negedge clk);
         check("vec_nframes", 32'(log_ch.size()), 32'(vecs[i].n_frames));
         if (log_ch.size() > 0 && log_err.size() > 0) begin
            check("vec_ch0", 32'(log_ch[0]), 32'(vecs[i].e_ch0));
            check("vec_data0", 32'(log_data[0]), 32'(vecs[i].e_d0));
            check("vec_err0", 32'(log_err[0]), 32'(vecs[i].e_err0));
         end
         if (vecs[i].n_frames > 1 && log_ch.size() > 1 && log_err.size() > 1) begin
            check("vec_ch1", 32'(log_ch[1]), 32'(vecs[i].e_ch1));
            check("vec_data1", 32'(log_data[1]), 32'(vecs[i].e_d1));
            check("vec_err1", 32'(log_err[1]), 32'(vecs[i].e_err1));
            check("vec_spacing", 32'(log_edge[1] - log_edge[0]), 32'(SPACING));
         end
      end

      // Producer holds valid high, bumping data after each accept.
      reset_dut();
      base    = done_cnt;
      a_data  = 12'h100;
      a_valid = 1'b1;
      k       = 0;
      while (done_cnt < base + 3 && k < 3 * SPACING + 50) begin
         @(negedge clk);
         acc = o_a_ready;
         @(posedge clk);
         #1;
         if (acc) a_data = a_data + 12'h001;
         k++;
      end
      a_valid = 1'b0;
      check("b2b_dones", 32'(done_cnt - base), 32'd3);
      check("b2b_nframes", 32'(log_ch.size()), 32'd3);
      if (log_ch.size() >= 3) begin
         for (int j = 0; j < 3; j++) begin
            check("b2b_ch", 32'(log_ch[j]), 32'd0);
            check("b2b_data", 32'(log_data[j]), 32'(12'h100 + 12'(j)));
         end
         check("b2b_spacing1", 32'(log_edge[1] - log_edge[0]), 32'(SPACING));
         check("b2b_spacing2", 32'(log_edge[2] - log_edge[1]), 32'(SPACING));
      end

      // Reset at frame cycle 1000 with B waiting.
      reset_dut();
      a_valid = 1'b1;
      a_data  = 12'h3C3;
      b_valid = 1'b1;
      b_data  = 12'h777;
      @(posedge clk);
      #1;
      a_valid = 1'b0;
      b_valid = 1'b0;
      repeat (1001) @(posedge clk);
      check("pre_rst_tx_a", 32'(o_tx_a), 32'd1);
      check("pre_rst_b_ready", 32'(o_b_ready), 32'd0);
      base = done_cnt;
      #2 rst = 1'b1;
      #1;
      check("rst_tx_a", 32'(o_tx_a), 32'd0);
      check("rst_a_ready", 32'(o_a_ready), 32'd1);
      check("rst_b_ready", 32'(o_b_ready), 32'd1);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_done", 32'(o_done), 32'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_no_done", 32'(done_cnt), 32'(base));
      clear_logs();
      a_valid = 1'b1;
      a_data  = 12'h5A5;
      b_valid = 1'b1;
      b_data  = 12'hA5A;
      @(posedge clk);
      #1;
      a_valid = 1'b0;
      b_valid = 1'b0;
      wait_dones(base + 1, SPACING + 50);
      check("post_rst_nframes", 32'(log_ch.size()), 32'd1);
      if (log_ch.size() > 0) begin
         check("post_rst_ch", 32'(log_ch[0]), 32'd0);
         check("post_rst_data", 32'(log_data[0]), 32'h5A5);
      end

      // Random traffic against the reference model.
      reset_dut();
      base = done_cnt;
      for (int c = 0; c < 20000; c++) begin
         @(posedge clk);
         #1;
         a_valid = ($urandom_range(7) == 0);
         a_data  = 12'($urandom);
         b_valid = ($urandom_range(5) == 0);
         b_data  = 12'($urandom);
         i_cc    = ($urandom_range(1999) == 0);
      end
      a_valid = 1'b0;
      b_valid = 1'b0;
      i_cc    = 1'b0;
      check("rand_progress", 32'(done_cnt - base >= 6), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
